ip_filter_ctrl: RTL and testbench
=================================

Name: ip_filter_ctrl

Overview:
- Sequencing controller for the IPv4 blacklist filter.
- Owns a DEPTH-entry blacklist table with a single read port and one-entry-per-cycle scanning.
- Shares the table between two requesters: packet lookups (valid/ready in, valid/ready result out) and runtime configuration (add/delete/clear).
- Arbitrates between them round-robin, so the table is never modified during a scan.

Parameters:
DEPTH, 16, number of blacklist entries
IDX_W, $clog2(DEPTH), entry index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pkt_valid  in  1  lookup request valid
pkt_ready  out  1  lookup request accepted when pkt_valid && pkt_ready
pkt_src_ip  in  32  source IPv4 address
pkt_dst_ip  in  32  destination IPv4 address
res_valid  out  1  lookup result valid
res_ready  in  1  result consumed when res_valid && res_ready
res_block  out  1  1 = source or destination address blacklisted
res_hit_idx  out  IDX_W  lowest matching entry index; 0 on miss
cfg_valid  in  1  config request valid
cfg_ready  out  1  config request accepted when cfg_valid && cfg_ready
cfg_op  in  2  0 = ADD, 1 = DEL, 2 = CLEAR, 3 = reserved
cfg_idx  in  IDX_W  target entry
cfg_ip  in  32  address for ADD
cfg_done  out  1  one-cycle pulse, cycle after config accept
cfg_err  out  1  qualified by cfg_done; set for op 3 or cfg_idx >= DEPTH
table_count  out  IDX_W+1  number of valid entries

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE; all entry valid bits cleared.
  - table_count = 0; res_valid = res_block = res_hit_idx = 0; cfg_done = cfg_err = 0.
  - Round-robin pointer favours cfg.
  - Reset asserted mid-scan or mid-response discards the transaction; no result is issued.
- State machine: IDLE -> SCAN -> RESP -> IDLE. Config executes entirely from IDLE.
- IDLE arbitration:
  - pkt_ready = IDLE && pkt_valid && (!cfg_valid || rr_ptr == PKT).
  - cfg_ready = IDLE && cfg_valid && (!pkt_valid || rr_ptr == CFG).
  - Both are combinational. pkt_ready and cfg_ready are never high together.
  - On each grant, rr_ptr flips to the other requester. A lone requester is granted without waiting.
- Lookup timing (packet accepted at cycle T):
  - src and dst addresses are latched at T.
  - Entry i is read and compared at cycle T+1+i. An entry matches only if its valid bit is set and it equals src or dst.
  - The scan stops at the first match.
  - Hit at index k: res_valid rises at T+k+2, res_block = 1, res_hit_idx = k.
  - Miss: res_valid rises at T+DEPTH+1, res_block = 0, res_hit_idx = 0.
- RESP state:
  - res_valid and all result fields are held stable until res_ready; return to IDLE on the cycle after handshake.
  - res_valid, res_block and res_hit_idx return to 0 in IDLE.
  - No new request is accepted during SCAN or RESP; cfg_ready = 0 there, so configuration stalls.
- Config (accepted at T, table updated at edge T+1, cfg_done pulses in cycle T+1, table_count valid at T+1):
  - ADD: write cfg_ip and set valid at cfg_idx. Overwriting an already-valid entry leaves the count unchanged.
  - DEL: clear valid at cfg_idx. Deleting an invalid entry is a no-op, not an error.
  - CLEAR: clear all valid bits; count = 0; cfg_idx is ignored.
  - Error (op 3 or cfg_idx >= DEPTH): table unchanged, cfg_err = 1 with cfg_done.
- A packet accepted the cycle after a config sees the updated table.
- src == dst is legal; a single match sets res_block.

Optional Feature:
- Macro FILTER_STATS_EN.
- When defined:
  - Adds outputs stat_lookups[31:0] and stat_blocked[31:0], reset to 0.
  - stat_lookups increments on each result handshake; stat_blocked increments on each handshake with res_block = 1.
  - Both counters saturate at 0xFFFFFFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ip_filter_pkg:
  - IP_W = 32.
  - cfg_op_e {CFG_ADD, CFG_DEL, CFG_CLEAR, CFG_RSVD}.
  - ctrl_state_e {IDLE, SCAN, RESP}.
  - rr_e {RR_CFG, RR_PKT}.
- Sub-module ip_filter_table:
  - DEPTH x 32 storage plus valid bits.
  - One registered-address read port, one write/invalidate port, clear-all.
  - Owns the table_count counter.
- ip_filter_ctrl holds the FSM, arbiter, scan index and result registers.

Test Plan:
- Reset, then lookup src = 0xC0A80001, dst = 0x0A000001 on an empty table -> res_valid at T+17, res_block = 0, res_hit_idx = 0, table_count = 0.
- ADD idx 5 = 0xC0A80003, then lookup dst = 0xC0A80003 -> res_valid at T+7, res_block = 1, res_hit_idx = 5, table_count = 1.
- ADD idx 2 = 0x01020304 and idx 9 = 0x05060708; lookup src = 0x05060708, dst = 0x01020304 -> res_hit_idx = 2; DEL idx 2, repeat lookup -> res_hit_idx = 9.
- Hold cfg_valid and pkt_valid high continuously from reset -> grants alternate cfg, pkt, cfg, ...; cfg_ready stays 0 throughout SCAN and RESP.
- Hold res_ready = 0 for 5 cycles in RESP -> fields stable, no new grant; CLEAR after release -> table_count = 0, a repeat lookup misses.
- Config with cfg_op = 3, then cfg_idx = DEPTH (with DEPTH = 12) -> cfg_err = 1 with cfg_done, table_count unchanged; assert rst_n low mid-SCAN -> no res_valid, table empty.

Source files
------------

// File: rtl/ip_filter_pkg.sv
// Shared types for the IPv4 blacklist filter controller.
//   IP_W         : address width
//   cfg_op_e     : configuration opcodes (ADD / DEL / CLEAR / reserved)
//   ctrl_state_e : controller sequencing states
//   rr_e         : round-robin owner between config and packet requesters
package ip_filter_pkg;

  localparam int unsigned IP_W = 32;

  typedef enum logic [1:0] {
    CFG_ADD   = 2'd0,
    CFG_DEL   = 2'd1,
    CFG_CLEAR = 2'd2,
    CFG_RSVD  = 2'd3
  } cfg_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  typedef enum logic {
    RR_CFG = 1'b0,
    RR_PKT = 1'b1
  } rr_e;

endpackage

// File: rtl/ip_filter_table.sv
// Blacklist storage: DEPTH x IP_W entries plus per-entry valid bits.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears valid bits/count)
//   rd_addr      : read address, registered; rd_data/rd_valid reflect it next cycle
//   rd_data      : stored address at the registered read index
//   rd_valid     : valid bit at the registered read index (0 when out of range)
//   wr_en        : write wr_data at wr_idx and mark it valid
//   inv_en       : clear the valid bit at wr_idx
//   clr_all      : clear every valid bit
//   wr_idx       : target index for write/invalidate (caller guarantees < DEPTH)
//   wr_data      : address to store
//   count        : number of valid entries
module ip_filter_table
  import ip_filter_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [IP_W-1:0]  rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic             inv_en,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [IP_W-1:0]  wr_data,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  logic [IP_W-1:0]  mem_q [DEPTH];
  logic [IP_W-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             rd_in_range;

  always_comb begin
    mem_d     = mem_q;
    valid_d   = valid_q;
    count_d   = count_q;
    rd_addr_d = rd_addr;
    if (clr_all) begin
      valid_d = '0;
      count_d = '0;
    end else if (wr_en) begin
      mem_d[wr_idx]   = wr_data;
      valid_d[wr_idx] = 1'b1;
      // Overwriting a live entry keeps the population unchanged.
      if (!valid_q[wr_idx]) begin
        count_d = count_q + CNT_ONE;
      end
    end else if (inv_en) begin
      if (valid_q[wr_idx]) begin
        valid_d[wr_idx] = 1'b0;
        count_d         = count_q - CNT_ONE;
      end
    end
  end

  // Entry data carries no reset; only the valid bits define table contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // The scanner may run one index past the last entry; that read is masked.
  assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_W);
  assign rd_data     = rd_in_range ? mem_q[rd_addr_q] : '0;
  assign rd_valid    = rd_in_range && valid_q[rd_addr_q];
  assign count       = count_q;

endmodule

// File: rtl/ip_filter_ctrl.sv
// Sequencing controller for the IPv4 blacklist filter.
// Arbitrates round-robin between packet lookups and table configuration,
// scans the table one entry per cycle and holds the result until consumed.
// Optional build macro FILTER_STATS_EN adds saturating lookup/blocked counters.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   pkt_valid/pkt_ready        : lookup request handshake (ready combinational)
//   pkt_src_ip, pkt_dst_ip     : addresses to check
//   res_valid/res_ready        : lookup result handshake
//   res_block, res_hit_idx     : blacklisted flag, lowest matching index (0 on miss)
//   cfg_valid/cfg_ready        : config request handshake (ready combinational)
//   cfg_op, cfg_idx, cfg_ip    : opcode, target entry, address for ADD
//   cfg_done, cfg_err          : completion pulse and its error qualifier
//   table_count                : number of valid entries
//   stat_lookups, stat_blocked : (FILTER_STATS_EN only) result handshake counters
module ip_filter_ctrl
  import ip_filter_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [31:0]      pkt_src_ip,
  input  logic [31:0]      pkt_dst_ip,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_block,
  output logic [IDX_W-1:0] res_hit_idx,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_op,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [31:0]      cfg_ip,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W:0]   table_count
`ifdef FILTER_STATS_EN
  ,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_blocked
`endif
);

  localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  ctrl_state_e      state_q, state_d;
  rr_e              rr_q, rr_d;
  logic [IDX_W-1:0] scan_q, scan_d;
  logic [IP_W-1:0]  src_q, src_d;
  logic [IP_W-1:0]  dst_q, dst_d;
  logic             res_valid_q, res_valid_d;
  logic             res_block_q, res_block_d;
  logic [IDX_W-1:0] res_hit_idx_q, res_hit_idx_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             pkt_acc, cfg_acc;
  cfg_op_e          op;
  logic             cfg_idx_ok, cfg_bad;
  logic [IDX_W-1:0] rd_addr;
  logic [IP_W-1:0]  rd_data;
  logic             rd_valid;
  logic             entry_match;
  logic             tbl_wr, tbl_inv, tbl_clr;
  logic             res_hs;

  // Arbitration: the round-robin pointer only decides ties.
  assign pkt_ready = (state_q == IDLE) && pkt_valid && (!cfg_valid || (rr_q == RR_PKT));
  assign cfg_ready = (state_q == IDLE) && cfg_valid && (!pkt_valid || (rr_q == RR_CFG));
  assign pkt_acc   = pkt_valid && pkt_ready;
  assign cfg_acc   = cfg_valid && cfg_ready;

  // CLEAR ignores cfg_idx, so an out-of-range index only faults ADD/DEL.
  assign op         = cfg_op_e'(cfg_op);
  assign cfg_idx_ok = ({1'b0, cfg_idx} < DEPTH_W);
  assign cfg_bad    = (op == CFG_RSVD) || ((op != CFG_CLEAR) && !cfg_idx_ok);

  assign tbl_wr  = cfg_acc && !cfg_bad && (op == CFG_ADD);
  assign tbl_inv = cfg_acc && !cfg_bad && (op == CFG_DEL);
  assign tbl_clr = cfg_acc && (op == CFG_CLEAR);

  assign entry_match = rd_valid && ((rd_data == src_q) || (rd_data == dst_q));
  assign res_hs      = (state_q == RESP) && res_ready;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    scan_d        = scan_q;
    src_d         = src_q;
    dst_d         = dst_q;
    res_valid_d   = res_valid_q;
    res_block_d   = res_block_q;
    res_hit_idx_d = res_hit_idx_q;
    cfg_done_d    = 1'b0;
    cfg_err_d     = 1'b0;
    rd_addr       = '0;
    case (state_q)
      IDLE: begin
        // Read address 0 is presented here so entry 0 is compared on the
        // first SCAN cycle; SCAN then keeps the address one index ahead.
        if (pkt_acc) begin
          state_d = SCAN;
          rr_d    = RR_CFG;
          src_d   = pkt_src_ip;
          dst_d   = pkt_dst_ip;
          scan_d  = '0;
        end else if (cfg_acc) begin
          rr_d       = RR_PKT;
          cfg_done_d = 1'b1;
          cfg_err_d  = cfg_bad;
        end
      end
      SCAN: begin
        rd_addr = scan_q + IDX_ONE;
        if (entry_match) begin
          state_d       = RESP;
          res_valid_d   = 1'b1;
          res_block_d   = 1'b1;
          res_hit_idx_d = scan_q;
        end else if (scan_q == LAST_IDX) begin
          state_d       = RESP;
          res_valid_d   = 1'b1;
          res_block_d   = 1'b0;
          res_hit_idx_d = '0;
        end else begin
          scan_d = scan_q + IDX_ONE;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d       = IDLE;
          res_valid_d   = 1'b0;
          res_block_d   = 1'b0;
          res_hit_idx_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= RR_CFG;
      scan_q        <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      res_valid_q   <= 1'b0;
      res_block_q   <= 1'b0;
      res_hit_idx_q <= '0;
      cfg_done_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      scan_q        <= scan_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      res_valid_q   <= res_valid_d;
      res_block_q   <= res_block_d;
      res_hit_idx_q <= res_hit_idx_d;
      cfg_done_q    <= cfg_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_block   = res_block_q;
  assign res_hit_idx = res_hit_idx_q;
  assign cfg_done    = cfg_done_q;
  assign cfg_err     = cfg_err_q;

  ip_filter_table #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (tbl_wr),
    .inv_en   (tbl_inv),
    .clr_all  (tbl_clr),
    .wr_idx   (cfg_idx),
    .wr_data  (cfg_ip),
    .count    (table_count)
  );

`ifdef FILTER_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_blocked_q, stat_blocked_d;

  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_blocked_d = stat_blocked_q;
    if (res_hs && (stat_lookups_q != '1)) begin
      stat_lookups_d = stat_lookups_q + 32'd1;
    end
    if (res_hs && res_block_q && (stat_blocked_q != '1)) begin
      stat_blocked_d = stat_blocked_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups_q <= '0;
      stat_blocked_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_blocked_q <= stat_blocked_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_blocked = stat_blocked_q;
`else
  // Without statistics the handshake strobe only steers the FSM.
  logic unused_res_hs;
  assign unused_res_hs = res_hs;
`endif

endmodule

// File: tb/tb_ip_filter_ctrl.sv
// Scoreboard bench for ip_filter_ctrl: a DEPTH=16 instance for lookups and
// arbitration, a DEPTH=12 instance for out-of-range config indices.
module tb_ip_filter_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DEPTH = 16 instance
  logic        pkt_valid, pkt_ready, res_valid, res_ready, res_block;
  logic [31:0] pkt_src_ip, pkt_dst_ip, cfg_ip;
  logic [3:0]  res_hit_idx, cfg_idx;
  logic        cfg_valid, cfg_ready, cfg_done, cfg_err;
  logic [1:0]  cfg_op;
  logic [4:0]  table_count;
`ifdef FILTER_STATS_EN
  logic [31:0] stat_lookups, stat_blocked, b_stat_lookups, b_stat_blocked;
`endif

  // DEPTH = 12 instance
  logic        b_pkt_ready, b_res_valid, b_res_block;
  logic [3:0]  b_res_hit_idx, b_cfg_idx;
  logic        b_cfg_valid, b_cfg_ready, b_cfg_done, b_cfg_err;
  logic [1:0]  b_cfg_op;
  logic [31:0] b_cfg_ip;
  logic [4:0]  b_table_count;

  ip_filter_ctrl #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_src_ip(pkt_src_ip), .pkt_dst_ip(pkt_dst_ip),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_block(res_block), .res_hit_idx(res_hit_idx),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_ip(cfg_ip),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .table_count(table_count)
`ifdef FILTER_STATS_EN
    , .stat_lookups(stat_lookups), .stat_blocked(stat_blocked)
`endif
  );

  ip_filter_ctrl #(.DEPTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(1'b0), .pkt_ready(b_pkt_ready),
    .pkt_src_ip(32'h0), .pkt_dst_ip(32'h0),
    .res_valid(b_res_valid), .res_ready(1'b1),
    .res_block(b_res_block), .res_hit_idx(b_res_hit_idx),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
    .cfg_op(b_cfg_op), .cfg_idx(b_cfg_idx), .cfg_ip(b_cfg_ip),
    .cfg_done(b_cfg_done), .cfg_err(b_cfg_err),
    .table_count(b_table_count)
`ifdef FILTER_STATS_EN
    , .stat_lookups(b_stat_lookups), .stat_blocked(b_stat_blocked)
`endif
  );

  typedef struct { logic blk; logic [3:0] idx; int due; } res_exp_t;
  typedef struct { logic err; logic [4:0] cnt; int due; } cfg_exp_t;

  res_exp_t res_q[$];
  cfg_exp_t cfg_q[$];
  cfg_exp_t b_q[$];
  bit       grant_log[$];
  res_exp_t cur;

  int n_vec = 0, n_err = 0, cyc = 0, n_hs = 0, n_blk_hs = 0;
  bit busy = 0;
  logic       exp_blk, exp_err, b_exp_err;
  logic [3:0] exp_idx;
  logic [4:0] exp_cnt, b_exp_cnt;
  int         exp_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus-side observer: pushes the expected response on each accept.
  always @(negedge clk) begin
    if (busy) check("no_grant_while_busy", {pkt_ready, cfg_ready}, 2'b00);
    if (pkt_ready || cfg_ready) check("ready_exclusive", pkt_ready & cfg_ready, 1'b0);
    if (pkt_valid && pkt_ready) begin
      res_q.push_back('{exp_blk, exp_idx, cyc + exp_lat});
      busy = 1;
      grant_log.push_back(1'b1);
    end
    if (cfg_valid && cfg_ready) begin
      cfg_q.push_back('{exp_err, exp_cnt, cyc + 1});
      grant_log.push_back(1'b0);
    end
  end

  // Result monitor.
  logic rv_prev = 1'b0;
  bit   hs_prev = 0;
  always @(negedge clk) begin
    if (hs_prev) check("res_idle_zero", {res_valid, res_block, res_hit_idx}, 6'd0);
    hs_prev = 0;
    if (res_valid && !rv_prev) begin
      if (res_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL res_unexpected: res_valid rose at cycle %0d with nothing outstanding", cyc);
        cur = '{1'b0, 4'd0, 0};
      end else begin
        cur = res_q.pop_front();
        check("res_block", res_block, cur.blk);
        check("res_hit_idx", res_hit_idx, cur.idx);
        check("res_latency", cyc, cur.due);
      end
    end else if (res_valid) begin
      check("res_hold", {res_block, res_hit_idx}, {cur.blk, cur.idx});
    end
    if (res_valid && res_ready) begin
      hs_prev = 1;
      busy = 0;
      n_hs++;
      if (res_block) n_blk_hs++;
    end
    rv_prev = res_valid;
  end

  // Config monitors.
  always @(negedge clk) begin
    if (cfg_done) begin
      if (cfg_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL cfg_unexpected: cfg_done at cycle %0d with nothing outstanding", cyc);
      end else begin
        cfg_exp_t e;
        e = cfg_q.pop_front();
        check("cfg_err", cfg_err, e.err);
        check("table_count", table_count, e.cnt);
        check("cfg_done_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (b_cfg_valid && b_cfg_ready) b_q.push_back('{b_exp_err, b_exp_cnt, cyc + 1});
  end

  always @(negedge clk) begin
    if (b_cfg_done) begin
      if (b_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_cfg_unexpected: cfg_done at cycle %0d with nothing outstanding", cyc);
      end else begin
        cfg_exp_t e;
        e = b_q.pop_front();
        check("b_cfg_err", b_cfg_err, e.err);
        check("b_table_count", b_table_count, e.cnt);
        check("b_cfg_done_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_idle(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (res_q.size() == 0 && cfg_q.size() == 0 && b_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pkt_grant();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pkt_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("pkt_grant");
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
  endtask

  task automatic wait_cfg_grant();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("cfg_grant");
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [1:0] op, input logic [3:0] idx, input logic [31:0] ip,
                        input logic err, input logic [4:0] cnt);
    exp_err = err; exp_cnt = cnt;
    cfg_op = op; cfg_idx = idx; cfg_ip = ip; cfg_valid = 1'b1;
    wait_cfg_grant();
    wait_idle(50);
  endtask

  task automatic do_cfg12(input logic [1:0] op, input logic [3:0] idx, input logic [31:0] ip,
                          input logic err, input logic [4:0] cnt);
    bit ok = 0;
    b_exp_err = err; b_exp_cnt = cnt;
    b_cfg_op = op; b_cfg_idx = idx; b_cfg_ip = ip; b_cfg_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_cfg_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("b_cfg_grant");
    @(posedge clk);
    #1;
    b_cfg_valid = 1'b0;
    wait_idle(50);
  endtask

  task automatic do_lookup(input logic [31:0] src, input logic [31:0] dst,
                           input logic blk, input logic [3:0] idx, input int lat);
    exp_blk = blk; exp_idx = idx; exp_lat = lat;
    pkt_src_ip = src; pkt_dst_ip = dst; pkt_valid = 1'b1;
    wait_pkt_grant();
    wait_idle(100);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    res_q.delete();
    cfg_q.delete();
    b_q.delete();
    busy = 0;
    n_hs = 0;
    n_blk_hs = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    pkt_valid = 0; pkt_src_ip = '0; pkt_dst_ip = '0; res_ready = 1'b1;
    cfg_valid = 0; cfg_op = '0; cfg_idx = '0; cfg_ip = '0;
    b_cfg_valid = 0; b_cfg_op = '0; b_cfg_idx = '0; b_cfg_ip = '0;
    exp_blk = 0; exp_idx = '0; exp_lat = 0; exp_err = 0; exp_cnt = '0;
    b_exp_err = 0; b_exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_res", {res_valid, res_block, res_hit_idx}, 6'd0);
    check("rst_cfg", {cfg_done, cfg_err}, 2'b00);
    check("rst_count", table_count, 5'd0);
    @(posedge clk);
    #1;

    // Empty table: miss after a full scan.
    do_lookup(32'hC0A80001, 32'h0A000001, 1'b0, 4'd0, 17);
    check("count_empty", table_count, 5'd0);

    // Single entry hit via destination.
    do_cfg(2'd0, 4'd5, 32'hC0A80003, 1'b0, 5'd1);
    do_lookup(32'h08080808, 32'hC0A80003, 1'b1, 4'd5, 7);
    check("count_one", table_count, 5'd1);

    // Lowest matching index wins; delete exposes the next one.
    do_cfg(2'd0, 4'd2, 32'h01020304, 1'b0, 5'd2);
    do_cfg(2'd0, 4'd9, 32'h05060708, 1'b0, 5'd3);
    do_lookup(32'h05060708, 32'h01020304, 1'b1, 4'd2, 4);
    do_cfg(2'd1, 4'd2, 32'h0, 1'b0, 5'd2);
    do_lookup(32'h05060708, 32'h01020304, 1'b1, 4'd9, 11);
    do_cfg(2'd1, 4'd2, 32'h0, 1'b0, 5'd2);          // delete of invalid entry
    do_cfg(2'd0, 4'd9, 32'h05060708, 1'b0, 5'd2);   // overwrite keeps count

    // Result stall with a config request pending.
    res_ready = 1'b0;
    exp_blk = 1'b1; exp_idx = 4'd5; exp_lat = 7;
    pkt_src_ip = 32'h0; pkt_dst_ip = 32'hC0A80003; pkt_valid = 1'b1;
    wait_pkt_grant();
    exp_err = 1'b0; exp_cnt = 5'd0;
    cfg_op = 2'd2; cfg_idx = 4'd7; cfg_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; break; end
    end
    if (!ok) timeout("stall_res_valid");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_cfg_grant();
    wait_idle(50);
    check("count_clear", table_count, 5'd0);
    do_lookup(32'h0, 32'hC0A80003, 1'b0, 4'd0, 17);

    // Source equal to destination.
    do_cfg(2'd0, 4'd7, 32'h7F000001, 1'b0, 5'd1);
    do_lookup(32'h7F000001, 32'h7F000001, 1'b1, 4'd7, 9);

    // Reset in the middle of a scan discards the lookup.
    do_cfg(2'd0, 4'd0, 32'hAABBCCDD, 1'b0, 5'd2);
    exp_blk = 1'b0; exp_idx = 4'd0; exp_lat = 17;
    pkt_src_ip = 32'h22222222; pkt_dst_ip = 32'h11111111; pkt_valid = 1'b1;
    wait_pkt_grant();
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("count_after_reset", table_count, 5'd0);
    repeat (25) @(negedge clk);
    check("no_res_after_reset", res_valid, 1'b0);
    @(posedge clk);
    #1;
    do_lookup(32'hAABBCCDD, 32'h0, 1'b0, 4'd0, 17);

    // Both requesters held: grants alternate starting with config.
    do_reset();
    exp_err = 1'b0; exp_cnt = 5'd1;
    exp_blk = 1'b1; exp_idx = 4'd3; exp_lat = 5;
    cfg_op = 2'd0; cfg_idx = 4'd3; cfg_ip = 32'h0BADF00D;
    pkt_src_ip = 32'h0; pkt_dst_ip = 32'h0BADF00D;
    grant_log.delete();
    cfg_valid = 1'b1; pkt_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 5) begin ok = 1; break; end
    end
    if (!ok) timeout("alternate_grants");
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; pkt_valid = 1'b0;
    wait_idle(100);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check("grant_order", grant_log[i], (i % 2) == 1);
    end

    // Out-of-range index and reserved opcode on the DEPTH = 12 instance.
    do_cfg12(2'd0, 4'd0, 32'h01010101, 1'b0, 5'd1);
    do_cfg12(2'd3, 4'd1, 32'h02020202, 1'b1, 5'd1);
    do_cfg12(2'd0, 4'd12, 32'h03030303, 1'b1, 5'd1);
    do_cfg12(2'd1, 4'd13, 32'h0, 1'b1, 5'd1);
    do_cfg12(2'd0, 4'd11, 32'h04040404, 1'b0, 5'd2);

`ifdef FILTER_STATS_EN
    check("stat_lookups", stat_lookups, n_hs);
    check("stat_blocked", stat_blocked, n_blk_hs);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
